// File: rtl/wide_addsub_sequencer.sv
// wide_addsub_sequencer
// Multi-cycle WIDTH-bit adder/subtractor built around one shared 4-bit
// add/sub slice. One nibble is processed per clock, LSB first, with the
// inter-slice carry held in a register.
// Optional feature macro: ADDSUB_SEQ_OVERFLOW_EN (signed overflow output).
// Without the macro the overflow port is tied to 0.
// WIDTH must be a multiple of 4 and at least 4.
module wide_addsub_sequencer #(
    parameter int WIDTH  = 16,
    parameter int NSLICE = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [IDX_W-1:0] slice_idx_reg;
    logic             carry_reg;
    logic             op_sub_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;
    logic             carry_out_reg;

    // Slice datapath signals
    logic [3:0] a_nib [NSLICE];
    logic [3:0] b_nib [NSLICE];
    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic       slice_cin;
    logic [4:0] slice_full;
    logic [3:0] slice_sum;
    logic       slice_cout;
    logic       last_slice;
    logic       accept;

    // New work is only taken when no operation is in flight
    assign accept     = start && (state_reg != ST_RUN);
    assign last_slice = (slice_idx_reg == IDX_W'(NSLICE - 1));

    // Split latched operands into nibbles and merge the current slice sum
    // back into the result at the active nibble position.
    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
            assign result_next[4*gi +: 4] =
                (slice_idx_reg == IDX_W'(gi)) ? slice_sum : result_reg[4*gi +: 4];
        end
    endgenerate

    // The shared 4-bit slice: operand select, B inversion and carry-in
    always_comb begin
        slice_a    = a_nib[slice_idx_reg];
        slice_b    = b_nib[slice_idx_reg] ^ {4{op_sub_reg}};
        // Slice 0 takes the +1 of two's complement directly from the opcode
        slice_cin  = (slice_idx_reg == '0) ? op_sub_reg : carry_reg;
        slice_full = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};
        slice_sum  = slice_full[3:0];
        slice_cout = slice_full[4];
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_slice) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Sequencer state, operand latches and per-slice result updates
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            slice_idx_reg <= '0;
            carry_reg     <= 1'b0;
            op_sub_reg    <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg         <= a;
                b_reg         <= b;
                op_sub_reg    <= op_sub;
                slice_idx_reg <= '0;
                carry_reg     <= op_sub;
                result_reg    <= '0;
                carry_out_reg <= 1'b0;
            end else if (state_reg == ST_RUN) begin
                result_reg <= result_next;
                carry_reg  <= slice_cout;
                if (last_slice) begin
                    carry_out_reg <= slice_cout;
                    slice_idx_reg <= '0;
                end else begin
                    slice_idx_reg <= slice_idx_reg + IDX_W'(1);
                end
            end
        end
    end

`ifdef ADDSUB_SEQ_OVERFLOW_EN
    logic [3:0] slice_low;
    logic       slice_ovf;
    logic       overflow_reg;

    // Carry into bit 3 versus carry out of bit 3 gives signed overflow
    always_comb begin
        slice_low = {1'b0, slice_a[2:0]} + {1'b0, slice_b[2:0]} + {3'b0, slice_cin};
        slice_ovf = slice_low[3] ^ slice_cout;
    end

    // Overflow is captured only on the MSB slice, alongside carry_out
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (accept) begin
            overflow_reg <= 1'b0;
        end else if (state_reg == ST_RUN && last_slice) begin
            overflow_reg <= slice_ovf;
        end
    end

    assign overflow = overflow_reg;
`else
    assign overflow = 1'b0;
`endif

    assign busy      = (state_reg == ST_RUN);
    assign done      = (state_reg == ST_DONE);
    assign result    = result_reg;
    assign carry_out = carry_out_reg;

endmodule

// File: tb/tb_wide_addsub_sequencer.sv
// Testbench for wide_addsub_sequencer (WIDTH=16): directed vector table,
// hand-written multi-cycle sequences, and random operations checked
// against an arithmetic reference model.
module tb_wide_addsub_sequencer;

    localparam int W = 16;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    wide_addsub_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         op;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] res;
        logic         co;
        logic         ov;   // overflow expected when the feature is enabled
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the raw vectors
    task automatic model(input logic op, input logic [W-1:0] ma, input logic [W-1:0] mb,
                         output logic [W-1:0] r, output logic co, output logic ov);
        logic [W:0] full;
        if (op) full = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
        else    full = {1'b0, ma} + {1'b0, mb};
        r  = full[W-1:0];
        co = full[W];
        if (op) ov = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
        else    ov = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
    endtask

    // Issue one operation, measure latency, check done is a single pulse
    task automatic do_op(input string tag, input logic op, input logic [W-1:0] va,
                         input logic [W-1:0] vb, output logic [W-1:0] r,
                         output logic co, output logic ov);
        int n;
        @(negedge clk);
        start = 1'b1; op_sub = op; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 5);
        r = result; co = carry_out; ov = overflow;
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] r, er;
        logic         co, ov, eco, eov;
        int           n;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, carry_out, overflow, result}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].va, vecs[i].vb, r, co, ov);
            chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
            chk($sformatf("vec%0d_carry", i), 32'(co), 32'(vecs[i].co));
            chk($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ov & OVF_EN));
            $display("vec%0d op=%0d a=%h b=%h -> result=%h co=%0d ov=%0d", i,
                     vecs[i].op, vecs[i].va, vecs[i].vb, r, co, ov);
        end

        // Nibble-by-nibble progress; previous result (0x7FFF) must clear
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; a = 16'h1234; b = 16'h1111;
        @(posedge clk); #1;
        start = 1'b0;
        chk("seq_cleared", 32'(result), 32'h0);
        @(posedge clk); #1; chk("seq_e1", 32'(result), 32'h0005);
        @(posedge clk); #1; chk("seq_e2", 32'(result), 32'h0045);
        @(posedge clk); #1; chk("seq_e3", 32'(result), 32'h0345);
        chk("seq_e3_not_done", 32'(done), 32'd0);
        @(posedge clk); #1; chk("seq_e4", 32'(result), 32'h2345);
        chk("seq_e4_done", 32'(done), 32'd1);
        $display("seq nibble progress result=%h", result);

        // Full ripple: carry_out only appears at completion
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            chk($sformatf("ripple_e%0d_result", e), 32'(result), 32'h0);
            chk($sformatf("ripple_e%0d_carry", e), 32'(carry_out), (e == 4) ? 32'd1 : 32'd0);
        end
        $display("ripple result=%h co=%0d", result, carry_out);
        @(posedge clk); #1;

        // start pulsed mid-operation is ignored
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; a = 16'h1000; b = 16'h0234;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b1; op_sub = 1'b1; a = 16'hAAAA; b = 16'h5555;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("ignore_done_seen", 32'(done), 32'd1);
        chk("ignore_result", 32'(result), 32'h1234);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done || busy) n++;
        end
        chk("ignore_no_second_op", n, 0);
        $display("ignore-mid-run result=%h", result);

        // Reset abort after E2
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; a = 16'h1111; b = 16'h1111;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_partial", 32'(result), 32'h0022);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_outputs", {busy, done, carry_out, overflow, result}, 32'd0);
        @(negedge clk); rst = 1'b0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done || busy) n++;
        end
        chk("abort_no_done", n, 0);
        $display("reset abort result=%h busy=%0d", result, busy);

        // Back-to-back: start held through the DONE cycle
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; a = 16'h0102; b = 16'h0304;
        @(posedge clk); #1;
        op_sub = 1'b1; a = 16'h1000; b = 16'h0001;
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("b2b_first_latency", n, 5);
        chk("b2b_first_result", 32'(result), 32'h0406);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_second_accepted", {30'd0, busy, done}, 32'd2);
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("b2b_second_latency", n, 5);
        chk("b2b_second_result", 32'(result), 32'h0FFF);
        chk("b2b_second_carry", 32'(carry_out), 32'd1);
        $display("back-to-back second result=%h co=%0d", result, carry_out);
        @(posedge clk); #1;

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic         rop;
            logic [W-1:0] ra, rb;
            rop = 1'($urandom_range(0, 1));
            ra  = W'($urandom);
            rb  = W'($urandom);
            model(rop, ra, rb, er, eco, eov);
            do_op($sformatf("rnd%0d", i), rop, ra, rb, r, co, ov);
            chk($sformatf("rnd%0d_result", i), 32'(r), 32'(er));
            chk($sformatf("rnd%0d_carry", i), 32'(co), 32'(eco));
            chk($sformatf("rnd%0d_ovf", i), 32'(ov), 32'(eov & OVF_EN));
            $display("rnd%0d op=%0d a=%h b=%h -> result=%h co=%0d ov=%0d", i,
                     rop, ra, rb, r, co, ov);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
